// File: rtl/adc_sequencer.sv
// Conversion sequencer for the ramp ADC handler: enable/finish handshake, valid/ready result, sticky errors.
// Optional group averaging of 2^OS_LOG2 conversions per result under `define ADC_SEQUENCER_OVERSAMPLE_EN.
module adc_sequencer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 512,
    parameter int unsigned RECOVER_CYCLES = 4
`ifdef ADC_SEQUENCER_OVERSAMPLE_EN
    ,
    parameter int unsigned OS_LOG2        = 2
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              clear_err,
    output logic              adc_enable,
    input  logic              adc_finished,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] result_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              timeout,
    output logic              overrun
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned REC_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_RECOVER
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [REC_W-1:0]  rec_cnt;

    logic              got_sample;
    logic              conv_tmo;
    logic              rec_done;
    logic              xfer;
    logic              capture;
    logic [DATA_W-1:0] cap_data;
    logic              stay_in_group;

    // A finished flag in the timeout cycle still counts as a good capture.
    assign got_sample = (state == S_CONVERT) && adc_finished;
    assign conv_tmo   = (state == S_CONVERT) && !adc_finished && (cyc_cnt == CNT_LAST);
    assign rec_done   = (state == S_RECOVER) && (rec_cnt == REC_LAST) && !adc_finished;
    assign xfer       = result_valid && result_ready;

`ifdef ADC_SEQUENCER_OVERSAMPLE_EN
    localparam int unsigned ACC_W = DATA_W + OS_LOG2;
    localparam int unsigned GRP_W = (OS_LOG2 > 0) ? OS_LOG2 : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << OS_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [GRP_W-1:0] grp_cnt;
    logic             group_end;

    assign acc_sum       = acc + ACC_W'(adc_data);
    assign group_end     = (grp_cnt == GRP_LAST);
    assign capture       = got_sample && group_end;
    assign cap_data      = DATA_W'(acc_sum >> OS_LOG2);
    assign stay_in_group = (grp_cnt != '0);

    // Group accumulator; a timeout throws away the partial group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            grp_cnt <= '0;
        end else if (conv_tmo || capture) begin
            acc     <= '0;
            grp_cnt <= '0;
        end else if (got_sample) begin
            acc     <= acc_sum;
            grp_cnt <= grp_cnt + GRP_W'(1);
        end
    end
`else
    assign capture       = got_sample;
    assign cap_data      = adc_data;
    assign stay_in_group = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cyc_cnt      <= '0;
            rec_cnt      <= '0;
            adc_enable   <= 1'b0;
            busy         <= 1'b0;
            result_data  <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_CONVERT;
                        adc_enable <= 1'b1;
                        busy       <= 1'b1;
                        cyc_cnt    <= '0;
                    end
                end
                S_CONVERT: begin
                    if (got_sample || conv_tmo) begin
                        state      <= S_RECOVER;
                        adc_enable <= 1'b0;
                        rec_cnt    <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    if (rec_done) begin
                        if (continuous || stay_in_group) begin
                            state      <= S_CONVERT;
                            adc_enable <= 1'b1;
                            cyc_cnt    <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (rec_cnt != REC_LAST) begin
                        rec_cnt <= rec_cnt + REC_W'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    adc_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase

            // Result slot: a new capture beats a same-cycle transfer.
            if (capture) begin
                result_data  <= cap_data;
                result_valid <= 1'b1;
            end else if (xfer) begin
                result_valid <= 1'b0;
            end

            if (conv_tmo) begin
                timeout <= 1'b1;
            end else if (clear_err) begin
                timeout <= 1'b0;
            end

            if (capture && result_valid && !result_ready) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Control-side counterpart of the ramp ADC handler. It drives the handler's enable, waits for the handler's finished flag, and captures the handler's 8-bit count.
- Presents each capture as a result word on a valid/ready interface to the downstream consumer.
- Supports single-shot and continuous conversion modes.
- Raises sticky timeout and overrun errors.

Parameters:
- DATA_W, 8, width of the ADC count and of the result word.
- TIMEOUT_CYCLES, 512, maximum number of clk cycles with adc_enable high before a conversion is aborted.
- RECOVER_CYCLES, 4, minimum number of clk cycles adc_enable is held low between conversions.
- OS_LOG2, 2, log2 of the oversampling factor; used only when OVERSAMPLE_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request for a conversion; ignored while busy=1.
- continuous  in  1  sampled at the end of RECOVER; 1 starts the next conversion automatically.
- clear_err  in  1  one-cycle clear of the timeout and overrun flags.
- adc_enable  out  1  enable to the ADC handler.
- adc_finished  in  1  conversion-done flag from the handler; level-sensitive.
- adc_data  in  DATA_W  count from the handler; valid while adc_finished=1.
- result_data  out  DATA_W  captured conversion result.
- result_valid  out  1  result available; held high until result_ready.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky: a conversion was aborted.
- overrun  out  1  sticky: an unread result was overwritten.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; adc_enable, result_valid, busy, timeout and overrun = 0; result_data = 0; all counters = 0.
- IDLE: if start=1 at an edge, go to CONVERT. adc_enable and busy rise at the next edge, so start at edge N gives adc_enable=1 after edge N.
- CONVERT:
  - adc_enable=1; a cycle counter increments every clk.
  - If adc_finished=1 at edge k: capture adc_data into result_data, set result_valid=1 and drop adc_enable at edge k+1, then go to RECOVER. Capture latency is 1 cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without adc_finished: set timeout=1, drop adc_enable, go to RECOVER, and do not update result_data or result_valid.
  - adc_finished and the timeout in the same cycle: the capture wins and timeout is not set.
- RECOVER:
  - adc_enable=0 for at least RECOVER_CYCLES cycles and until adc_finished=0 is sampled.
  - On exit: if continuous=1, go to CONVERT; otherwise go to IDLE.
- Result handshake:
  - A transfer occurs on any edge where result_valid=1 and result_ready=1; result_valid clears at that edge.
  - A capture while result_valid=1 and no transfer in the same cycle: result_data is overwritten, result_valid stays 1, overrun is set.
  - A capture in the same cycle as a transfer: no overrun; result_valid stays 1 and carries the new data.
- Errors: clear_err=1 clears timeout and overrun at the next edge. If an error event occurs in the same cycle, the set wins.
- start while busy=1 has no effect. Deasserting continuous during CONVERT completes that conversion, then returns to IDLE.
- Counter widths: the cycle counter is clog2(TIMEOUT_CYCLES) bits and the recover counter is clog2(RECOVER_CYCLES+1) bits. Both reset to 0 on entry to their state.

Optional Feature:
- Macro ADC_SEQUENCER_OVERSAMPLE_EN.
- Defined:
  - Each result is the average of 2^OS_LOG2 consecutive conversions, each with its own CONVERT/RECOVER pair.
  - An accumulator of DATA_W+OS_LOG2 bits sums the captures. result_data is the accumulator shifted right by OS_LOG2 (truncated), and result_valid is set only after the last conversion of the group.
  - A timeout discards the partial group and zeroes the accumulator.
  - In single-shot mode, one start runs the whole group. An intermediate RECOVER ignores continuous and returns to CONVERT.
- Undefined: there is no accumulator and every conversion produces a result.

Test Plan:
- Reset then start, ADC model asserts adc_finished with adc_data=8'hA5 after 300 cycles -> adc_enable high 1 cycle after start; result_data=8'hA5 and result_valid=1 one cycle after finished; adc_enable low; busy stays high through RECOVER, then returns to 0.
- ADC model never finishes -> timeout=1 after 512 cycles with adc_enable high; result_valid stays 0. Then clear_err pulse -> timeout=0.
- continuous=1, result_ready=0, model returns 8'h10 then 8'h20 -> result_data=8'h20, overrun=1, result_valid=1. Then result_ready=1 -> result_valid=0 next edge.
- continuous=1 with result_ready tied high, three conversions -> three transfers; adc_enable low for at least 4 cycles between conversions; no overrun.
- Assert reset=0 mid-CONVERT -> adc_enable, busy and result_valid drop immediately without a clock edge. After release, start works normally.
- With ADC_SEQUENCER_OVERSAMPLE_EN, OS_LOG2=2, samples 10, 11, 12, 14 -> a single result of 11 (47>>2) after the fourth conversion.
